// File: rtl/sin_phase_decoder_pkg.sv
// Shared constants, FSM encoding and quarter-wave table generator for the
// sine amplitude-to-phase decoder.
package sin_phase_decoder_pkg;

  localparam int unsigned AMP_W       = 16;
  localparam int unsigned PHASE_W     = 10;
  localparam int unsigned QW_STEPS    = 1 << (PHASE_W - 2);
  localparam int unsigned QW_DEPTH    = QW_STEPS + 1;
  localparam int unsigned SEARCH_BITS = 9;
  localparam int unsigned ADDR_W      = 9;
  localparam int unsigned BIT_W       = 4;

  localparam logic [AMP_W-1:0] FULL_SCALE = 16'd32767;
  localparam logic [AMP_W-1:0] MOST_NEG   = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RD,
    CMP,
    DONE
  } state_t;

  // round(32767*sin(2*pi*k/1024)) evaluated at elaboration; the Taylor series
  // is carried far enough that double-precision error never moves a rounding.
  function automatic logic [AMP_W-1:0] qw_entry(input int unsigned k);
    real x;
    real x2;
    real term;
    real acc;
    x    = 2.0 * 3.14159265358979323846 * real'(k) / real'(1 << PHASE_W);
    x2   = x * x;
    term = x;
    acc  = x;
    for (int unsigned n = 1; n < 16; n++) begin
      term = -term * x2 / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return AMP_W'($rtoi(real'(FULL_SCALE) * acc + 0.5));
  endfunction

endpackage

// File: rtl/sin_phase_decoder_if.sv
// Request/result bundle between a sample source and the phase decoder.
interface sin_phase_decoder_if;

  logic                                              i_en;
  logic signed [sin_phase_decoder_pkg::AMP_W-1:0]    i_data;
  logic                                              o_busy;
  logic                                              o_vld;
  logic        [sin_phase_decoder_pkg::PHASE_W-1:0]  o_phase;

  modport slave (
    input  i_en,
    input  i_data,
    output o_busy,
    output o_vld,
    output o_phase
  );

  modport master (
    output i_en,
    output i_data,
    input  o_busy,
    input  o_vld,
    input  o_phase
  );

endinterface

// File: rtl/sin_qw_rom.sv
// 257 x 16 quarter-wave sine amplitude table with a registered read port.
module sin_qw_rom
  import sin_phase_decoder_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [AMP_W-1:0]  data_o
);

  logic [AMP_W-1:0] tab [QW_DEPTH];
  logic [AMP_W-1:0] data_q;

  for (genvar g = 0; g < QW_DEPTH; g++) begin : g_tab
    localparam logic [AMP_W-1:0] ENTRY = qw_entry(g);
    assign tab[g] = ENTRY;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= tab[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/sin_phase_decoder.sv
// Recovers the principal-value phase of a signed sine sample by a 9-step
// binary search over the quarter-wave ROM; fixed 21-cycle latency.
module sin_phase_decoder
  import sin_phase_decoder_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  sin_phase_decoder_if.slave  bus
);

  state_t               state_q, state_d;
  logic                 sign_q, sign_d;
  logic [AMP_W-1:0]     amp_q, amp_d;
  logic [ADDR_W-1:0]    k_q, k_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 vld_q, vld_d;

  logic [AMP_W-1:0]     in_raw;
  logic [AMP_W-1:0]     in_mag;
  logic [ADDR_W-1:0]    trial;
  logic                 trial_ok;
  logic [ADDR_W-1:0]    rom_addr;
  logic [AMP_W-1:0]     rom_data;

  assign in_raw = bus.i_data;

  always_comb begin
    in_mag = in_raw;
    if (in_raw == MOST_NEG) begin
      in_mag = FULL_SCALE;
    end else if (in_raw[AMP_W-1]) begin
      in_mag = '0 - in_raw;
    end
  end

  // Out-of-range trials still read a legal address; CMP discards the data.
  assign trial    = k_q | (ADDR_W'(1) << bit_q);
  assign trial_ok = (trial <= ADDR_W'(QW_STEPS));
  assign rom_addr = trial_ok ? trial : ADDR_W'(QW_STEPS);

  sin_qw_rom u_rom (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    amp_d   = amp_q;
    k_d     = k_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    vld_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_en) begin
          sign_d  = in_raw[AMP_W-1];
          amp_d   = in_mag;
          state_d = LOAD;
        end
      end
      LOAD: begin
        k_d     = '0;
        bit_d   = BIT_W'(SEARCH_BITS - 1);
        state_d = RD;
      end
      RD: begin
        state_d = CMP;
      end
      CMP: begin
        if (trial_ok && (rom_data <= amp_q)) begin
          k_d = trial;
        end
        if (bit_q == '0) begin
          state_d = DONE;
        end else begin
          bit_d   = bit_q - BIT_W'(1);
          state_d = RD;
        end
      end
      DONE: begin
        phase_d = sign_q ? (PHASE_W'(0) - PHASE_W'(k_q)) : PHASE_W'(k_q);
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      amp_q   <= '0;
      k_q     <= '0;
      bit_q   <= '0;
      phase_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      amp_q   <= amp_d;
      k_q     <= k_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.o_busy  = (state_q != IDLE);
  assign bus.o_vld   = vld_q;
  assign bus.o_phase = phase_q;

endmodule

// File: tb/tb_sin_phase_decoder.sv
// Scoreboard bench for sin_phase_decoder: directed points, loopback sweep,
// busy rejection, mid-search reset, back-to-back and random samples.
module tb_sin_phase_decoder;

  localparam real PI = 3.14159265358979323846;

  typedef struct {
    int unsigned cyc;
    logic [9:0]  ph;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sin_phase_decoder_if bus ();

  sin_phase_decoder dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  exp_t        sb[$];
  int unsigned cyc      = 0;
  int unsigned acc_cyc  = 0;
  bit          inflight = 1'b0;
  logic [9:0]  hold_ph  = '0;
  int unsigned n_vec    = 0;
  int unsigned n_err    = 0;
  int          qrom[257];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int round_sin(input int unsigned p);
    real v;
    v = 32767.0 * $sin(2.0 * PI * real'(p) / 1024.0);
    if (v < 0.0) return -$rtoi(-v + 0.5);
    return $rtoi(v + 0.5);
  endfunction

  // Largest table index whose amplitude does not exceed |d|, then folded.
  function automatic logic [9:0] ref_phase(input logic signed [15:0] d);
    int a;
    int k;
    a = (d < 0) ? -int'(d) : int'(d);
    if (a > 32767) a = 32767;
    k = 0;
    for (int j = 0; j <= 256; j++) begin
      if (qrom[j] <= a) k = j;
    end
    if (d < 0) return 10'((1024 - k) % 1024);
    return 10'(k);
  endfunction

  always @(negedge clk) begin
    logic busy_exp;
    exp_t e;
    busy_exp = inflight && (cyc >= acc_cyc) && (cyc <= acc_cyc + 19);
    n_vec++;
    if (bus.o_busy !== busy_exp) begin
      n_err++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.o_busy, busy_exp);
    end
    if (bus.o_vld === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_vld cyc=%0d phase=%0d exp=no strobe", cyc, bus.o_phase);
      end else begin
        e = sb.pop_front();
        hold_ph = e.ph;
        if (e.cyc != cyc) begin
          n_err++;
          $display("FAIL vld_timing got cyc=%0d exp cyc=%0d", cyc, e.cyc);
        end
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL missing_vld cyc=%0d exp phase=%0d at cyc=%0d", cyc, sb[0].ph, sb[0].cyc);
      void'(sb.pop_front());
    end
    n_vec++;
    if (bus.o_phase !== hold_ph) begin
      n_err++;
      $display("FAIL phase cyc=%0d got=%0d exp=%0d", cyc, bus.o_phase, hold_ph);
    end
  end

  // Called at negedge+1; the request is accepted at the coming rising edge.
  task automatic step(input logic en, input logic signed [15:0] d, input logic [9:0] ph);
    bus.i_en   = en;
    bus.i_data = d;
    if (en && (!inflight || (cyc + 1 >= acc_cyc + 21))) begin
      acc_cyc  = cyc + 1;
      inflight = 1'b1;
      sb.push_back('{cyc: cyc + 21, ph: ph});
    end
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] d, input logic [9:0] ph);
    step(1'b1, d, ph);
    for (int i = 0; i < 20; i++) step(1'b0, 16'sd0, 10'd0);
  endtask

  typedef struct {
    logic signed [15:0] d;
    logic [9:0]         ph;
  } pt_t;

  pt_t pts[9] = '{
    '{16'sd0,      10'd0},   '{16'sd200,    10'd0},   '{16'sd201,    10'd1},
    '{16'sd23170,  10'd128}, '{16'sd32767,  10'd256}, '{-16'sd201,   10'd1023},
    '{-16'sd23170, 10'd896}, '{-16'sd32767, 10'd768}, '{16'sh8000,   10'd768}
  };

  initial begin
    logic signed [15:0] d;
    int unsigned        exp_p;
    for (int k = 0; k <= 256; k++) qrom[k] = round_sin(k);
    bus.i_en   = 1'b0;
    bus.i_data = '0;

    #1000;
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 16'sd0, 10'd0);

    foreach (pts[i]) send(pts[i].d, pts[i].ph);

    // Second request lands while busy and is dropped.
    step(1'b1, 16'sd23170, 10'd128);
    for (int i = 0; i < 4; i++) step(1'b0, 16'sd0, 10'd0);
    step(1'b1, 16'sd0, 10'd0);
    for (int i = 0; i < 20; i++) step(1'b0, 16'sd0, 10'd0);

    // Reset in mid-search discards the conversion.
    step(1'b1, 16'sd32767, 10'd256);
    for (int i = 0; i < 8; i++) step(1'b0, 16'sd0, 10'd0);
    sb.delete();
    inflight = 1'b0;
    hold_ph  = '0;
    rst      = 1'b1;
    step(1'b0, 16'sd0, 10'd0);
    step(1'b0, 16'sd0, 10'd0);
    rst = 1'b0;
    send(16'sd201, 10'd1);

    for (int unsigned p = 0; p < 1024; p++) begin
      if (p <= 256 || p >= 768) exp_p = p;
      else                      exp_p = (1536 - p) % 1024;
      send(16'(round_sin(p)), 10'(exp_p));
    end

    for (int i = 0; i < 230; i++) begin
      d = 16'($urandom);
      step(1'b1, d, ref_phase(d));
    end
    step(1'b0, 16'sd0, 10'd0);

    for (int i = 0; i < 150; i++) begin
      d = 16'($urandom);
      send(d, ref_phase(d));
    end

    for (int i = 0; i < 50 && sb.size() > 0; i++) step(1'b0, 16'sd0, 10'd0);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
